count_snapshot_fifo: RTL and testbench
======================================

Name: count_snapshot_fifo

Overview:
- Downstream consumer of the 4-bit counter stage. Samples count0_Pad..count3_Pad on every GCLK_Pad pulse.
- On a snapshot request it pushes the current count value into a small show-ahead FIFO, which a readout stage drains with a pop handshake.
- Detects counter wrap-around (15 -> 0) and flags drops caused by overflow, so that host-side checkers never lose or misread counter state.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- GCLK_Pad  input  1  single clock; all state updates on rising edge.
- rst_Pad  input  1  asynchronous, active-high reset; clears all state immediately.
- count0_Pad  input  1  counter bit 0 (LSB) from upstream counter.
- count1_Pad  input  1  counter bit 1.
- count2_Pad  input  1  counter bit 2.
- count3_Pad  input  1  counter bit 3 (MSB).
- snap_Pad  input  1  snapshot request; sampled at rising edge.
- rd_Pad  input  1  pop request; sampled at rising edge.
- dout0_Pad..dout3_Pad  output  1 each  head-of-FIFO value, bits 0..3.
- valid_Pad  output  1  FIFO non-empty; dout is meaningful.
- full_Pad  output  1  FIFO holds DEPTH entries.
- ovf_Pad  output  1  sticky: a push was dropped.
- wrap_Pad  output  1  one-cycle registered pulse on a 15 -> 0 counter transition.

Behaviour:
- Reset (async, rst_Pad=1): all outputs are forced to 0. This clears pointers, entry count, ovf, wrap, the prev-count register and prev_ok. Reset asserted mid-operation discards all FIFO contents. The first edge after release behaves as the first cycle after power-up.
- cur = {count3,count2,count1,count0}, unsigned 4-bit.
- Sampling: every edge, prev <= cur and prev_ok <= 1.
- Wrap detect: at an edge where prev_ok=1, prev=15 and cur=0, wrap_Pad=1 for exactly one cycle; otherwise 0. No wrap is reported on the first edge after reset. Transitions 15 -> nonzero or x -> 0 with x≠15 are not wraps.
- Push request: push_req = snap_Pad (plus the wrap condition when the optional feature is enabled). Push data = cur at that edge, not prev.
- Pop request: pop_req = rd_Pad & valid_Pad. rd_Pad while empty is ignored, with no state change.
- Occupancy, per edge:
  - push only, not full: write at wptr; wptr+1 mod DEPTH; cnt+1.
  - push only, full: value dropped; ovf_Pad <= 1, sticky until reset.
  - pop only: rptr+1 mod DEPTH; cnt-1.
  - push and pop, not empty: both succeed, including when full (pop frees the slot the same edge); cnt unchanged; no overflow.
  - push and pop while empty: pop ignored, push succeeds.
- Pointer wrap: wptr and rptr are AW bits and roll over naturally. cnt is AW+1 bits, range 0..DEPTH.
- Flags: valid_Pad = (cnt≠0); full_Pad = (cnt=DEPTH). Both are registered, updating on the same edge as cnt.
- Show-ahead data: dout = mem[rptr] whenever valid_Pad=1, else 0000.
  - A push into an empty FIFO at edge N gives valid_Pad=1 and dout=pushed value after edge N, i.e. one-cycle latency.
  - After a pop at edge N, dout shows the next entry after edge N.
- No combinational path from any input to any output.

Optional Feature:
- Macro: COUNT_SNAP_AUTOWRAP_EN.
- Defined: the wrap condition also generates a push, so push_req = snap_Pad | wrap_cond. If both occur on the same edge, exactly one entry (value 0) is pushed.
- Undefined: only snap_Pad pushes; wrap_Pad is still generated but has no effect on the FIFO.

Test Plan:
- Reset release, counter held at 0, no snap/rd for 5 edges -> valid_Pad=0, full_Pad=0, ovf_Pad=0, wrap_Pad=0, dout=0000 throughout.
- Counter at 3, snap_Pad one edge, then counter at 9, snap one edge -> valid_Pad=1 with dout=0011. Pulse rd_Pad: dout=1001. Pulse rd_Pad again: valid_Pad=0, dout=0000.
- Five snaps (values 1..5) with no rd -> full_Pad=1 after the 4th; 5th dropped, ovf_Pad=1 and stays 1. Draining yields 1,2,3,4. Second reset clears ovf_Pad.
- FIFO full, snap and rd on the same edge (cur=7) -> head pops, 7 written at tail, full_Pad stays 1, ovf_Pad stays 0.
- Counter steps 14,15,0,1 -> wrap_Pad=1 for exactly the cycle after the 15->0 edge. With COUNT_SNAP_AUTOWRAP_EN defined, one entry 0000 is queued; undefined, the FIFO stays empty.
- rst_Pad pulsed mid-cycle with 3 entries queued -> all outputs 0 immediately, without waiting for GCLK_Pad. The next snap after release is the sole entry.

Source files
------------

// File: rtl/count_snapshot_fifo_if.sv
// Pad-level bundle between the counter stage, the snapshot FIFO and the readout stage.
// master drives the counter bits and the snap/rd requests; slave is the FIFO side.
interface count_snapshot_fifo_if;
    logic count0_Pad;
    logic count1_Pad;
    logic count2_Pad;
    logic count3_Pad;
    logic snap_Pad;
    logic rd_Pad;
    logic dout0_Pad;
    logic dout1_Pad;
    logic dout2_Pad;
    logic dout3_Pad;
    logic valid_Pad;
    logic full_Pad;
    logic ovf_Pad;
    logic wrap_Pad;

    modport master (
        output count0_Pad, count1_Pad, count2_Pad, count3_Pad, snap_Pad, rd_Pad,
        input  dout0_Pad, dout1_Pad, dout2_Pad, dout3_Pad, valid_Pad, full_Pad, ovf_Pad, wrap_Pad
    );

    modport slave (
        input  count0_Pad, count1_Pad, count2_Pad, count3_Pad, snap_Pad, rd_Pad,
        output dout0_Pad, dout1_Pad, dout2_Pad, dout3_Pad, valid_Pad, full_Pad, ovf_Pad, wrap_Pad
    );
endinterface

// File: rtl/count_snapshot_fifo.sv
// Snapshot FIFO for the 4-bit counter: queues count values on snap, flags wrap and overflow.
// Optional: define COUNT_SNAP_AUTOWRAP_EN to also push a 0 entry on every 15 -> 0 wrap.
module count_snapshot_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic GCLK_Pad,
    input  logic rst_Pad,
    count_snapshot_fifo_if.slave bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          wrap_q, wrap_d;
    logic [3:0]    prev_q, prev_d;
    logic          prev_ok_q, prev_ok_d;

    logic [3:0] cur;
    logic [3:0] dout;
    logic       wrap_cond;
    logic       push_req;
    logic       pop_req;

    assign cur = {bus.count3_Pad, bus.count2_Pad, bus.count1_Pad, bus.count0_Pad};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        prev_d    = cur;
        prev_ok_d = 1'b1;

        wrap_cond = prev_ok_q && (prev_q == 4'hF) && (cur == 4'h0);
        wrap_d    = wrap_cond;
`ifdef COUNT_SNAP_AUTOWRAP_EN
        push_req  = bus.snap_Pad | wrap_cond;
`else
        push_req  = bus.snap_Pad;
`endif
        pop_req   = bus.rd_Pad & valid_q;

        // A simultaneous pop frees the head slot, so a push into a full FIFO still fits.
        if (push_req && pop_req) begin
            mem_d[wptr_q] = cur;
            wptr_d        = wptr_q + AW'(1);
            rptr_d        = rptr_q + AW'(1);
        end else if (push_req) begin
            if (full_q) begin
                ovf_d = 1'b1;
            end else begin
                mem_d[wptr_q] = cur;
                wptr_d        = wptr_q + AW'(1);
                cnt_d         = cnt_q + (AW+1)'(1);
            end
        end else if (pop_req) begin
            rptr_d = rptr_q + AW'(1);
            cnt_d  = cnt_q - (AW+1)'(1);
        end

        valid_d = (cnt_d != '0);
        full_d  = (cnt_d == FULL_CNT);
    end

    always_ff @(posedge GCLK_Pad or posedge rst_Pad) begin
        if (rst_Pad) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'h0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wrap_q    <= 1'b0;
            prev_q    <= 4'h0;
            prev_ok_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            wrap_q    <= wrap_d;
            prev_q    <= prev_d;
            prev_ok_q <= prev_ok_d;
        end
    end

    assign dout          = valid_q ? mem_q[rptr_q] : 4'h0;
    assign bus.dout0_Pad = dout[0];
    assign bus.dout1_Pad = dout[1];
    assign bus.dout2_Pad = dout[2];
    assign bus.dout3_Pad = dout[3];
    assign bus.valid_Pad = valid_q;
    assign bus.full_Pad  = full_q;
    assign bus.ovf_Pad   = ovf_q;
    assign bus.wrap_Pad  = wrap_q;
endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench for count_snapshot_fifo; honours COUNT_SNAP_AUTOWRAP_EN when defined.
module tb_count_snapshot_fifo;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    count_snapshot_fifo_if bus();

    count_snapshot_fifo #(.DEPTH(4), .AW(2)) dut (
        .GCLK_Pad (clk),
        .rst_Pad  (rst),
        .bus      (bus)
    );

    logic [3:0] dout;
    assign dout = {bus.dout3_Pad, bus.dout2_Pad, bus.dout1_Pad, bus.dout0_Pad};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_count(input logic [3:0] v);
        bus.count0_Pad = v[0];
        bus.count1_Pad = v[1];
        bus.count2_Pad = v[2];
        bus.count3_Pad = v[3];
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        bus.snap_Pad = 1'b0;
        bus.rd_Pad   = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.valid_Pad !== 1'b0) begin fails++; $display("[TB] FAIL rst_hold_valid: got %b, expected 0", bus.valid_Pad); end
        checks++; if (dout !== 4'h0) begin fails++; $display("[TB] FAIL rst_hold_dout: got %h, expected 0", dout); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus.valid_Pad !== 1'b0) begin fails++; $display("[TB] FAIL idle_valid[%0d]: got %b, expected 0", i, bus.valid_Pad); end
            checks++; if (bus.full_Pad !== 1'b0) begin fails++; $display("[TB] FAIL idle_full[%0d]: got %b, expected 0", i, bus.full_Pad); end
            checks++; if (bus.ovf_Pad !== 1'b0) begin fails++; $display("[TB] FAIL idle_ovf[%0d]: got %b, expected 0", i, bus.ovf_Pad); end
            checks++; if (bus.wrap_Pad !== 1'b0) begin fails++; $display("[TB] FAIL idle_wrap[%0d]: got %b, expected 0", i, bus.wrap_Pad); end
            checks++; if (dout !== 4'h0) begin fails++; $display("[TB] FAIL idle_dout[%0d]: got %h, expected 0", i, dout); end
        end
    endtask

    task automatic test_two_snaps();
        set_count(4'd3);
        bus.snap_Pad = 1'b1;
        step();
        checks++; if (bus.valid_Pad !== 1'b1) begin fails++; $display("[TB] FAIL snap1_valid: got %b, expected 1", bus.valid_Pad); end
        checks++; if (dout !== 4'h3) begin fails++; $display("[TB] FAIL snap1_dout: got %h, expected 3", dout); end
        set_count(4'd9);
        step();
        bus.snap_Pad = 1'b0;
        checks++; if (dout !== 4'h3) begin fails++; $display("[TB] FAIL snap2_head: got %h, expected 3", dout); end
        bus.rd_Pad = 1'b1;
        step();
        bus.rd_Pad = 1'b0;
        checks++; if (dout !== 4'h9) begin fails++; $display("[TB] FAIL pop1_dout: got %h, expected 9", dout); end
        checks++; if (bus.valid_Pad !== 1'b1) begin fails++; $display("[TB] FAIL pop1_valid: got %b, expected 1", bus.valid_Pad); end
        bus.rd_Pad = 1'b1;
        step();
        bus.rd_Pad = 1'b0;
        checks++; if (bus.valid_Pad !== 1'b0) begin fails++; $display("[TB] FAIL pop2_valid: got %b, expected 0", bus.valid_Pad); end
        checks++; if (dout !== 4'h0) begin fails++; $display("[TB] FAIL pop2_dout: got %h, expected 0", dout); end
        bus.rd_Pad = 1'b1;
        step();
        bus.rd_Pad = 1'b0;
        checks++; if (bus.valid_Pad !== 1'b0) begin fails++; $display("[TB] FAIL rd_empty_valid: got %b, expected 0", bus.valid_Pad); end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.snap_Pad = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            set_count(4'(i));
            step();
            if (i == 3) begin
                checks++; if (bus.full_Pad !== 1'b0) begin fails++; $display("[TB] FAIL ovf_full3: got %b, expected 0", bus.full_Pad); end
            end
            if (i == 4) begin
                checks++; if (bus.full_Pad !== 1'b1) begin fails++; $display("[TB] FAIL ovf_full4: got %b, expected 1", bus.full_Pad); end
                checks++; if (bus.ovf_Pad !== 1'b0) begin fails++; $display("[TB] FAIL ovf_early: got %b, expected 0", bus.ovf_Pad); end
            end
        end
        bus.snap_Pad = 1'b0;
        checks++; if (bus.ovf_Pad !== 1'b1) begin fails++; $display("[TB] FAIL ovf_set: got %b, expected 1", bus.ovf_Pad); end
        checks++; if (bus.full_Pad !== 1'b1) begin fails++; $display("[TB] FAIL ovf_full5: got %b, expected 1", bus.full_Pad); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (dout !== 4'(i)) begin fails++; $display("[TB] FAIL drain_dout[%0d]: got %h, expected %h", i, dout, 4'(i)); end
            bus.rd_Pad = 1'b1;
            step();
            bus.rd_Pad = 1'b0;
        end
        checks++; if (bus.valid_Pad !== 1'b0) begin fails++; $display("[TB] FAIL drain_valid: got %b, expected 0", bus.valid_Pad); end
        checks++; if (bus.ovf_Pad !== 1'b1) begin fails++; $display("[TB] FAIL ovf_sticky: got %b, expected 1", bus.ovf_Pad); end
        do_reset();
        checks++; if (bus.ovf_Pad !== 1'b0) begin fails++; $display("[TB] FAIL ovf_cleared: got %b, expected 0", bus.ovf_Pad); end
    endtask

    task automatic test_back_to_back();
        int exp_vals [4] = '{2, 3, 4, 7};
        do_reset();
        bus.snap_Pad = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_count(4'(i));
            step();
        end
        set_count(4'd7);
        bus.rd_Pad = 1'b1;
        step();
        bus.snap_Pad = 1'b0;
        bus.rd_Pad   = 1'b0;
        checks++; if (bus.full_Pad !== 1'b1) begin fails++; $display("[TB] FAIL b2b_full: got %b, expected 1", bus.full_Pad); end
        checks++; if (bus.ovf_Pad !== 1'b0) begin fails++; $display("[TB] FAIL b2b_ovf: got %b, expected 0", bus.ovf_Pad); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dout !== 4'(exp_vals[i])) begin fails++; $display("[TB] FAIL b2b_dout[%0d]: got %h, expected %h", i, dout, 4'(exp_vals[i])); end
            bus.rd_Pad = 1'b1;
            step();
            bus.rd_Pad = 1'b0;
        end
        checks++; if (bus.valid_Pad !== 1'b0) begin fails++; $display("[TB] FAIL b2b_empty: got %b, expected 0", bus.valid_Pad); end
    endtask

    task automatic test_wrap();
        logic exp_valid;
`ifdef COUNT_SNAP_AUTOWRAP_EN
        exp_valid = 1'b1;
`else
        exp_valid = 1'b0;
`endif
        set_count(4'd15);
        do_reset();
        set_count(4'd0);
        step();
        checks++; if (bus.wrap_Pad !== 1'b0) begin fails++; $display("[TB] FAIL wrap_first_edge: got %b, expected 0", bus.wrap_Pad); end
        set_count(4'd14);
        step();
        set_count(4'd15);
        step();
        checks++; if (bus.wrap_Pad !== 1'b0) begin fails++; $display("[TB] FAIL wrap_14_15: got %b, expected 0", bus.wrap_Pad); end
        set_count(4'd0);
        step();
        checks++; if (bus.wrap_Pad !== 1'b1) begin fails++; $display("[TB] FAIL wrap_pulse: got %b, expected 1", bus.wrap_Pad); end
        checks++; if (bus.valid_Pad !== exp_valid) begin fails++; $display("[TB] FAIL wrap_push_valid: got %b, expected %b", bus.valid_Pad, exp_valid); end
        checks++; if (dout !== 4'h0) begin fails++; $display("[TB] FAIL wrap_push_dout: got %h, expected 0", dout); end
        set_count(4'd1);
        step();
        checks++; if (bus.wrap_Pad !== 1'b0) begin fails++; $display("[TB] FAIL wrap_one_cycle: got %b, expected 0", bus.wrap_Pad); end
        checks++; if (bus.valid_Pad !== exp_valid) begin fails++; $display("[TB] FAIL wrap_hold_valid: got %b, expected %b", bus.valid_Pad, exp_valid); end
        set_count(4'd15);
        step();
        set_count(4'd3);
        step();
        checks++; if (bus.wrap_Pad !== 1'b0) begin fails++; $display("[TB] FAIL wrap_15_3: got %b, expected 0", bus.wrap_Pad); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.snap_Pad = 1'b1;
        set_count(4'd2); step();
        set_count(4'd5); step();
        set_count(4'd8); step();
        bus.snap_Pad = 1'b0;
        checks++; if (dout !== 4'h2) begin fails++; $display("[TB] FAIL ar_head: got %h, expected 2", dout); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.valid_Pad !== 1'b0) begin fails++; $display("[TB] FAIL ar_valid: got %b, expected 0", bus.valid_Pad); end
        checks++; if (dout !== 4'h0) begin fails++; $display("[TB] FAIL ar_dout: got %h, expected 0", dout); end
        checks++; if (bus.full_Pad !== 1'b0) begin fails++; $display("[TB] FAIL ar_full: got %b, expected 0", bus.full_Pad); end
        #1;
        rst = 1'b0;
        set_count(4'd6);
        bus.snap_Pad = 1'b1;
        step();
        bus.snap_Pad = 1'b0;
        checks++; if (dout !== 4'h6) begin fails++; $display("[TB] FAIL ar_new_dout: got %h, expected 6", dout); end
        bus.rd_Pad = 1'b1;
        step();
        bus.rd_Pad = 1'b0;
        checks++; if (bus.valid_Pad !== 1'b0) begin fails++; $display("[TB] FAIL ar_sole_entry: got %b, expected 0", bus.valid_Pad); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.snap_Pad = 1'b0;
        bus.rd_Pad   = 1'b0;
        set_count(4'd0);
        test_reset();
        test_two_snaps();
        test_overflow();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
